// File: rtl/hdlc_rx_frame_ctrl_if.sv
// rtl/hdlc_rx_frame_ctrl_if.sv - Rx frame controller signal bundle (datapath/software side vs controller side)
interface hdlc_rx_frame_ctrl_if;
  logic       RxEN;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_NewByte;
  logic [7:0] Rx_Data;
  logic       Rx_ReadBuff;
  logic       Rx_Drop;
  logic       Rx_ValidFrame;
  logic       Rx_WrBuff;
  logic       Rx_AbortSignal;
  logic       Rx_Overflow;
  logic       Rx_FrameError;
  logic       Rx_Ready;
  logic [7:0] Rx_FrameSize;
  logic [7:0] Rx_DataBuff;

  modport master (
    output RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_Data, Rx_ReadBuff, Rx_Drop,
    input  Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow, Rx_FrameError, Rx_Ready,
           Rx_FrameSize, Rx_DataBuff
  );

  modport slave (
    input  RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_Data, Rx_ReadBuff, Rx_Drop,
    output Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow, Rx_FrameError, Rx_Ready,
           Rx_FrameSize, Rx_DataBuff
  );
endinterface

// File: rtl/hdlc_rx_frame_ctrl.sv
// rtl/hdlc_rx_frame_ctrl.sv - HDLC receive frame FSM and byte buffer
// Define HDLC_RX_FCS_STRIP_EN to hide the two trailing FCS bytes from Rx_FrameSize.
module hdlc_rx_frame_ctrl #(
  parameter int BUF_DEPTH = 128
) (
  input logic                 Clk,
  input logic                 Rst,
  hdlc_rx_frame_ctrl_if.slave rxIf
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [7:0] DEPTH = 8'(BUF_DEPTH);
`ifdef HDLC_RX_FCS_STRIP_EN
  localparam logic [7:0] FCS_BYTES = 8'd2;
`else
  localparam logic [7:0] FCS_BYTES = 8'd0;
`endif

  typedef enum logic [1:0] {IDLE, FRAME, READY} state_t;

  state_t     state, stateNxt;
  logic [7:0] byteCnt;   // doubles as the write pointer
  logic [7:0] rdPtr;
  logic [7:0] frameSize;
  logic       abortSig, overflow, frameErr;
  logic [7:0] rxBuf [BUF_DEPTH];

  logic openFrame, wrEn, setOverflow, setFrameErr, setAbort, dropBytes, closeFrame, rdAdv;

  always_comb begin
    stateNxt    = state;
    openFrame   = 1'b0;
    wrEn        = 1'b0;
    setOverflow = 1'b0;
    setFrameErr = 1'b0;
    setAbort    = 1'b0;
    dropBytes   = 1'b0;
    closeFrame  = 1'b0;
    rdAdv       = 1'b0;
    case (state)
      IDLE: begin
        if (rxIf.RxEN && rxIf.Rx_FlagDetect) begin
          openFrame = 1'b1;
          stateNxt  = FRAME;
        end
      end
      FRAME: begin
        if (!rxIf.RxEN) begin
          stateNxt = IDLE;
        end else if (rxIf.Rx_AbortDetect) begin
          setAbort = 1'b1;
          stateNxt = IDLE;
        end else if (rxIf.Rx_FlagDetect) begin
          // An empty frame is just a repeated flag; a short one is discarded and the flag reopens.
          if (byteCnt >= 8'd3) begin
            closeFrame = 1'b1;
            stateNxt   = READY;
          end else if (byteCnt != 8'd0) begin
            setFrameErr = 1'b1;
            dropBytes   = 1'b1;
          end
        end else if (rxIf.Rx_NewByte) begin
          if (byteCnt < DEPTH) wrEn = 1'b1;
          else                 setOverflow = 1'b1;
        end
      end
      READY: begin
        if (!rxIf.RxEN || rxIf.Rx_Drop) begin
          stateNxt = IDLE;
        end else if (rxIf.Rx_ReadBuff) begin
          rdAdv = 1'b1;
          if (rdPtr == frameSize - 8'd1) stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      byteCnt   <= 8'd0;
      rdPtr     <= 8'd0;
      frameSize <= 8'd0;
      abortSig  <= 1'b0;
      overflow  <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      state <= stateNxt;
      if (openFrame) begin
        byteCnt  <= 8'd0;
        abortSig <= 1'b0;
        overflow <= 1'b0;
        frameErr <= 1'b0;
      end
      if (wrEn)        byteCnt  <= byteCnt + 8'd1;
      if (dropBytes)   byteCnt  <= 8'd0;
      if (setOverflow) overflow <= 1'b1;
      if (setFrameErr) frameErr <= 1'b1;
      if (setAbort)    abortSig <= 1'b1;
      if (closeFrame) begin
        frameSize <= byteCnt - FCS_BYTES;
        rdPtr     <= 8'd0;
      end
      if (rdAdv) rdPtr <= rdPtr + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (wrEn) rxBuf[byteCnt[AW-1:0]] <= rxIf.Rx_Data;
  end

  assign rxIf.Rx_ValidFrame  = (state == FRAME);
  assign rxIf.Rx_Ready       = (state == READY);
  assign rxIf.Rx_WrBuff      = wrEn;
  assign rxIf.Rx_AbortSignal = abortSig;
  assign rxIf.Rx_Overflow    = overflow;
  assign rxIf.Rx_FrameError  = frameErr;
  assign rxIf.Rx_FrameSize   = frameSize;
  assign rxIf.Rx_DataBuff    = (state == READY) ? rxBuf[rdPtr[AW-1:0]] : 8'h00;
endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// tb/tb_hdlc_rx_frame_ctrl.sv - randomized self-checking bench for hdlc_rx_frame_ctrl
module tb_hdlc_rx_frame_ctrl;
  localparam int DEPTH = 16;
`ifdef HDLC_RX_FCS_STRIP_EN
  localparam int STRIP = 2;
`else
  localparam int STRIP = 0;
`endif

  logic       Clk;
  logic       Rst;
  int         nCompared = 0;
  int         nFailed   = 0;
  logic [7:0] txQ[$];

  hdlc_rx_frame_ctrl_if rxIf();

  hdlc_rx_frame_ctrl #(.BUF_DEPTH(DEPTH)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .rxIf (rxIf)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Readable bytes of a frame that carried n bytes.
  function automatic int exp_size(input int n);
    return ((n > DEPTH) ? DEPTH : n) - STRIP;
  endfunction

  task automatic pulse(input bit flag, input bit abort, input bit nb, input logic [7:0] data,
                       input bit rd, input bit drop, output bit wr);
    rxIf.Rx_FlagDetect  = flag;
    rxIf.Rx_AbortDetect = abort;
    rxIf.Rx_NewByte     = nb;
    rxIf.Rx_Data        = data;
    rxIf.Rx_ReadBuff    = rd;
    rxIf.Rx_Drop        = drop;
    @(negedge Clk);
    wr = rxIf.Rx_WrBuff;
    @(posedge Clk);
    #1;
    rxIf.Rx_FlagDetect  = 1'b0;
    rxIf.Rx_AbortDetect = 1'b0;
    rxIf.Rx_NewByte     = 1'b0;
    rxIf.Rx_ReadBuff    = 1'b0;
    rxIf.Rx_Drop        = 1'b0;
  endtask

  task automatic send_flag();
    bit wr;
    pulse(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, wr);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic make_random(input int n);
    txQ.delete();
    for (int i = 0; i < n; i++) txQ.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_bytes(input int maxGap, output int wrCount);
    bit wr;
    wrCount = 0;
    foreach (txQ[i]) begin
      idle_cycles(int'($urandom_range(0, maxGap)));
      pulse(1'b0, 1'b0, 1'b1, txQ[i], 1'b0, 1'b0, wr);
      if (wr) wrCount++;
    end
  endtask

  task automatic test_reset();
    rxIf.RxEN = 1'b0;
    rxIf.Rx_FlagDetect = 1'b0;
    rxIf.Rx_AbortDetect = 1'b0;
    rxIf.Rx_NewByte = 1'b0;
    rxIf.Rx_Data = 8'h00;
    rxIf.Rx_ReadBuff = 1'b0;
    rxIf.Rx_Drop = 1'b0;
    Rst = 1'b1;
    #2 Rst = 1'b0;
    #1;
    nCompared++;
    if ({rxIf.Rx_ValidFrame, rxIf.Rx_WrBuff, rxIf.Rx_AbortSignal, rxIf.Rx_Overflow,
         rxIf.Rx_FrameError, rxIf.Rx_Ready} !== 6'b0) begin
      nFailed++;
      $display("FAIL reset_flags: got %b expected 000000", {rxIf.Rx_ValidFrame, rxIf.Rx_WrBuff,
               rxIf.Rx_AbortSignal, rxIf.Rx_Overflow, rxIf.Rx_FrameError, rxIf.Rx_Ready});
    end
    nCompared++;
    if (rxIf.Rx_FrameSize !== 8'h00) begin
      nFailed++;
      $display("FAIL reset_size: got %h expected 00", rxIf.Rx_FrameSize);
    end
    nCompared++;
    if (rxIf.Rx_DataBuff !== 8'h00) begin
      nFailed++;
      $display("FAIL reset_data: got %h expected 00", rxIf.Rx_DataBuff);
    end
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    rxIf.RxEN = 1'b1;
  endtask

  task automatic test_good_frame();
    int n, sz, wc;
    bit wr;
    for (int it = 0; it < 7; it++) begin
      if (it == 0) txQ = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      else         make_random(int'($urandom_range(3, DEPTH)));
      n = txQ.size();
      send_flag();
      send_bytes((it == 0) ? 0 : 2, wc);
      nCompared++;
      if (wc !== n) begin
        nFailed++;
        $display("FAIL good_wrbuff[%0d]: got %0d expected %0d", it, wc, n);
      end
      send_flag();
      nCompared++;
      if ({rxIf.Rx_Ready, rxIf.Rx_ValidFrame} !== 2'b10) begin
        nFailed++;
        $display("FAIL good_ready[%0d]: got %b expected 10", it, {rxIf.Rx_Ready, rxIf.Rx_ValidFrame});
      end
      sz = exp_size(n);
      nCompared++;
      if (rxIf.Rx_FrameSize !== 8'(sz)) begin
        nFailed++;
        $display("FAIL good_size[%0d]: got %0d expected %0d", it, rxIf.Rx_FrameSize, sz);
      end
      for (int i = 0; i < sz; i++) begin
        nCompared++;
        if (rxIf.Rx_DataBuff !== txQ[i]) begin
          nFailed++;
          $display("FAIL good_data[%0d][%0d]: got %h expected %h", it, i, rxIf.Rx_DataBuff, txQ[i]);
        end
        pulse(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, wr);
      end
      nCompared++;
      if ({rxIf.Rx_Ready, rxIf.Rx_ValidFrame} !== 2'b00) begin
        nFailed++;
        $display("FAIL good_idle[%0d]: got %b expected 00", it, {rxIf.Rx_Ready, rxIf.Rx_ValidFrame});
      end
    end
  endtask

  task automatic test_short_frame();
    int wc;
    bit wr;
    for (int n = 2; n >= 1; n--) begin
      send_flag();
      make_random(n);
      send_bytes(1, wc);
      send_flag();
      nCompared++;
      if ({rxIf.Rx_FrameError, rxIf.Rx_Ready, rxIf.Rx_ValidFrame} !== 3'b101) begin
        nFailed++;
        $display("FAIL short_err[%0d]: got %b expected 101", n,
                 {rxIf.Rx_FrameError, rxIf.Rx_Ready, rxIf.Rx_ValidFrame});
      end
      make_random(4);
      send_bytes(0, wc);
      send_flag();
      nCompared++;
      if ({rxIf.Rx_Ready, rxIf.Rx_FrameError} !== 2'b11) begin
        nFailed++;
        $display("FAIL short_next_ready[%0d]: got %b expected 11", n, {rxIf.Rx_Ready, rxIf.Rx_FrameError});
      end
      nCompared++;
      if (rxIf.Rx_FrameSize !== 8'(exp_size(4)) || rxIf.Rx_DataBuff !== txQ[0]) begin
        nFailed++;
        $display("FAIL short_next_frame[%0d]: got size %0d data %h expected size %0d data %h", n,
                 rxIf.Rx_FrameSize, rxIf.Rx_DataBuff, exp_size(4), txQ[0]);
      end
      pulse(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, wr);
      send_flag();
      nCompared++;
      if ({rxIf.Rx_FrameError, rxIf.Rx_ValidFrame} !== 2'b01) begin
        nFailed++;
        $display("FAIL short_clear[%0d]: got %b expected 01", n, {rxIf.Rx_FrameError, rxIf.Rx_ValidFrame});
      end
      pulse(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, wr);
    end
  endtask

  task automatic test_abort();
    int wc;
    bit wr;
    send_flag();
    make_random(3);
    send_bytes(1, wc);
    pulse(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, wr);
    nCompared++;
    if ({rxIf.Rx_AbortSignal, rxIf.Rx_ValidFrame, rxIf.Rx_Ready} !== 3'b100) begin
      nFailed++;
      $display("FAIL abort_set: got %b expected 100", {rxIf.Rx_AbortSignal, rxIf.Rx_ValidFrame, rxIf.Rx_Ready});
    end
    send_flag();
    nCompared++;
    if ({rxIf.Rx_AbortSignal, rxIf.Rx_ValidFrame} !== 2'b01) begin
      nFailed++;
      $display("FAIL abort_clear: got %b expected 01", {rxIf.Rx_AbortSignal, rxIf.Rx_ValidFrame});
    end
    make_random(3);
    send_bytes(0, wc);
    pulse(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, wr);
    nCompared++;
    if (wr !== 1'b0) begin
      nFailed++;
      $display("FAIL abort_prio_wr: got %b expected 0", wr);
    end
    nCompared++;
    if ({rxIf.Rx_AbortSignal, rxIf.Rx_ValidFrame, rxIf.Rx_Ready} !== 3'b100) begin
      nFailed++;
      $display("FAIL abort_prio_state: got %b expected 100",
               {rxIf.Rx_AbortSignal, rxIf.Rx_ValidFrame, rxIf.Rx_Ready});
    end
  endtask

  task automatic test_ready_ignore();
    int wc;
    bit wr;
    send_flag();
    make_random(3);
    send_bytes(1, wc);
    pulse(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, wr);
    nCompared++;
    if (wr !== 1'b0 || rxIf.Rx_Ready !== 1'b1) begin
      nFailed++;
      $display("FAIL flag_over_byte: got wr %b ready %b expected wr 0 ready 1", wr, rxIf.Rx_Ready);
    end
    nCompared++;
    if (rxIf.Rx_FrameSize !== 8'(exp_size(3))) begin
      nFailed++;
      $display("FAIL flag_over_byte_size: got %0d expected %0d", rxIf.Rx_FrameSize, exp_size(3));
    end
    pulse(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, wr);
    nCompared++;
    if ({wr, rxIf.Rx_Ready, rxIf.Rx_AbortSignal, rxIf.Rx_ValidFrame} !== 4'b0100) begin
      nFailed++;
      $display("FAIL ready_ignore: got %b expected 0100",
               {wr, rxIf.Rx_Ready, rxIf.Rx_AbortSignal, rxIf.Rx_ValidFrame});
    end
    nCompared++;
    if (rxIf.Rx_DataBuff !== txQ[0]) begin
      nFailed++;
      $display("FAIL ready_data: got %h expected %h", rxIf.Rx_DataBuff, txQ[0]);
    end
    pulse(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, wr);
    nCompared++;
    if ({rxIf.Rx_Ready, rxIf.Rx_ValidFrame} !== 2'b00) begin
      nFailed++;
      $display("FAIL drop_idle: got %b expected 00", {rxIf.Rx_Ready, rxIf.Rx_ValidFrame});
    end
  endtask

  task automatic test_overflow();
    int wc, sz;
    bit wr;
    send_flag();
    make_random(DEPTH + 1);
    send_bytes(1, wc);
    nCompared++;
    if (wc !== DEPTH) begin
      nFailed++;
      $display("FAIL ovf_wrbuff: got %0d expected %0d", wc, DEPTH);
    end
    send_flag();
    nCompared++;
    if ({rxIf.Rx_Overflow, rxIf.Rx_Ready, rxIf.Rx_FrameError} !== 3'b110) begin
      nFailed++;
      $display("FAIL ovf_flags: got %b expected 110", {rxIf.Rx_Overflow, rxIf.Rx_Ready, rxIf.Rx_FrameError});
    end
    sz = exp_size(DEPTH + 1);
    nCompared++;
    if (rxIf.Rx_FrameSize !== 8'(sz)) begin
      nFailed++;
      $display("FAIL ovf_size: got %0d expected %0d", rxIf.Rx_FrameSize, sz);
    end
    for (int i = 0; i < sz; i++) begin
      nCompared++;
      if (rxIf.Rx_DataBuff !== txQ[i]) begin
        nFailed++;
        $display("FAIL ovf_data[%0d]: got %h expected %h", i, rxIf.Rx_DataBuff, txQ[i]);
      end
      pulse(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, wr);
    end
    nCompared++;
    if ({rxIf.Rx_Ready, rxIf.Rx_Overflow} !== 2'b01) begin
      nFailed++;
      $display("FAIL ovf_idle: got %b expected 01", {rxIf.Rx_Ready, rxIf.Rx_Overflow});
    end
  endtask

  task automatic test_rxen();
    int wc;
    bit wr;
    send_flag();
    make_random(1);
    send_bytes(0, wc);
    send_flag();
    rxIf.RxEN = 1'b0;
    idle_cycles(1);
    nCompared++;
    if ({rxIf.Rx_ValidFrame, rxIf.Rx_FrameError} !== 2'b01) begin
      nFailed++;
      $display("FAIL rxen_off: got %b expected 01", {rxIf.Rx_ValidFrame, rxIf.Rx_FrameError});
    end
    send_flag();
    pulse(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, wr);
    nCompared++;
    if ({wr, rxIf.Rx_ValidFrame} !== 2'b00) begin
      nFailed++;
      $display("FAIL rxen_off_ignore: got %b expected 00", {wr, rxIf.Rx_ValidFrame});
    end
    rxIf.RxEN = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, wr);
    nCompared++;
    if (wr !== 1'b0) begin
      nFailed++;
      $display("FAIL rxen_idle_byte: got %b expected 0", wr);
    end
  endtask

  task automatic test_async_reset();
    int wc;
    bit wr;
    send_flag();
    make_random(5);
    send_bytes(0, wc);
    #2;
    rxIf.Rx_NewByte = 1'b1;
    Rst = 1'b0;
    #1;
    nCompared++;
    if ({rxIf.Rx_ValidFrame, rxIf.Rx_WrBuff, rxIf.Rx_Ready, rxIf.Rx_FrameSize, rxIf.Rx_DataBuff} !== 19'b0) begin
      nFailed++;
      $display("FAIL async_reset: got valid %b wr %b ready %b size %h data %h expected all 0",
               rxIf.Rx_ValidFrame, rxIf.Rx_WrBuff, rxIf.Rx_Ready, rxIf.Rx_FrameSize, rxIf.Rx_DataBuff);
    end
    @(posedge Clk);
    #1;
    rxIf.Rx_NewByte = 1'b0;
    Rst = 1'b1;
    make_random(4);
    send_bytes(1, wc);
    nCompared++;
    if (wc !== 0) begin
      nFailed++;
      $display("FAIL async_no_flag_wr: got %0d expected 0", wc);
    end
    send_flag();
    send_bytes(0, wc);
    nCompared++;
    if (wc !== 4) begin
      nFailed++;
      $display("FAIL async_after_flag_wr: got %0d expected 4", wc);
    end
    send_flag();
    nCompared++;
    if (rxIf.Rx_Ready !== 1'b1) begin
      nFailed++;
      $display("FAIL async_after_ready: got %b expected 1", rxIf.Rx_Ready);
    end
    pulse(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, wr);
  endtask

  task automatic test_back_to_back();
    int wc;
    bit wr;
    repeat (3) send_flag();
    nCompared++;
    if ({rxIf.Rx_ValidFrame, rxIf.Rx_FrameError, rxIf.Rx_Ready} !== 3'b100) begin
      nFailed++;
      $display("FAIL b2b_flags: got %b expected 100", {rxIf.Rx_ValidFrame, rxIf.Rx_FrameError, rxIf.Rx_Ready});
    end
    for (int k = 0; k < 3; k++) begin
      make_random(int'($urandom_range(3, 8)));
      send_bytes(0, wc);
      send_flag();
      nCompared++;
      if (rxIf.Rx_Ready !== 1'b1 || rxIf.Rx_FrameSize !== 8'(exp_size(txQ.size()))) begin
        nFailed++;
        $display("FAIL b2b_ready[%0d]: got ready %b size %0d expected ready 1 size %0d", k,
                 rxIf.Rx_Ready, rxIf.Rx_FrameSize, exp_size(txQ.size()));
      end
      pulse(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, wr);
      send_flag();
      nCompared++;
      if (rxIf.Rx_ValidFrame !== 1'b1) begin
        nFailed++;
        $display("FAIL b2b_reopen[%0d]: got %b expected 1", k, rxIf.Rx_ValidFrame);
      end
    end
    pulse(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, wr);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_abort();
    test_ready_ignore();
    test_overflow();
    test_rxen();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end
endmodule

// File: doc/hdlc_rx_frame_ctrl.md
HDLC_RX_FRAME_CTRL -- requirements
Module: hdlc_rx_frame_ctrl

Interface
REQ-001 Parameter BUF_DEPTH, default 128: receive buffer size in bytes; legal range 4..255.
REQ-002 Clk  in  1  sole clock; all logic samples on the rising edge.
REQ-003 Rst  in  1  asynchronous, active-low reset; Rst=0 forces the reset state immediately.
REQ-004 RxEN  in  1  receiver enable from the control register.
REQ-005 Rx_FlagDetect  in  1  one-cycle pulse when the Rx datapath detects a 01111110 flag.
REQ-006 Rx_AbortDetect  in  1  one-cycle pulse when the Rx datapath detects 7 or more consecutive ones.
REQ-007 Rx_NewByte  in  1  one-cycle pulse; Rx_Data holds a destuffed byte.
REQ-008 Rx_Data  in  8  received byte, qualified by Rx_NewByte.
REQ-009 Rx_ReadBuff  in  1  one-cycle pulse; software read of the data register.
REQ-010 Rx_Drop  in  1  one-cycle pulse; software discards the held frame.
REQ-011 Rx_ValidFrame  out  1  high while a frame is being received.
REQ-012 Rx_WrBuff  out  1  one-cycle pulse when a byte is written into the buffer.
REQ-013 Rx_AbortSignal  out  1  sticky; frame aborted.
REQ-014 Rx_Overflow  out  1  sticky; more than BUF_DEPTH bytes received.
REQ-015 Rx_FrameError  out  1  sticky; frame closed while too short.
REQ-016 Rx_Ready  out  1  high while a complete frame is held for reading.
REQ-017 Rx_FrameSize  out  8  number of readable bytes in the held frame.
REQ-018 Rx_DataBuff  out  8  buffer byte at the read pointer.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, FRAME, READY.
REQ-020 IDLE: a Rx_FlagDetect pulse while RxEN=1 -> FRAME next cycle; the same edge SHALL clear the write pointer, byte count, Rx_AbortSignal, Rx_Overflow and Rx_FrameError.
REQ-021 FRAME: Rx_ValidFrame=1. Each Rx_NewByte while count<BUF_DEPTH -> write Rx_Data at the write pointer, increment count, Rx_WrBuff=1 in the same cycle.
REQ-022 FRAME: Rx_NewByte while count=BUF_DEPTH -> set Rx_Overflow, no write, count saturates.
REQ-023 FRAME, Rx_FlagDetect with count=0 (back-to-back flags): stay in FRAME.
REQ-024 FRAME, Rx_FlagDetect with 0<count<3: set Rx_FrameError, discard the bytes, clear the count, stay in FRAME (the flag opens the next frame).
REQ-025 FRAME, Rx_FlagDetect with count>=3: -> READY, latch Rx_FrameSize, clear the read pointer.
REQ-026 FRAME, Rx_AbortDetect: set Rx_AbortSignal -> IDLE.
REQ-027 Same-cycle priority: Rx_AbortDetect > Rx_FlagDetect > Rx_NewByte; a lower-priority event in the same cycle SHALL be ignored.
REQ-028 READY: Rx_Ready=1, Rx_ValidFrame=0. Rx_DataBuff SHALL equal the buffer byte at the read pointer combinationally; each Rx_ReadBuff increments the read pointer.
REQ-029 READY -> IDLE on Rx_Drop, or on the Rx_ReadBuff that consumes byte Rx_FrameSize-1.
REQ-030 READY: Rx_FlagDetect, Rx_NewByte and Rx_AbortDetect SHALL be ignored, with no buffer writes.
REQ-031 Rx_ReadBuff outside READY SHALL have no effect.
REQ-032 RxEN=0 in any state -> IDLE next cycle; sticky flags are retained.
REQ-033 Rx_Overflow and Rx_FrameError SHALL remain visible in READY and SHALL clear only per REQ-020.

Reset
REQ-034 Rst=0 -> state IDLE; all pointers and counts 0; all outputs 0, including Rx_FrameSize and Rx_DataBuff.
REQ-035 Reset mid-FRAME or mid-READY SHALL discard the frame; buffer contents are don't-care.

Configuration
REQ-036 Macro HDLC_RX_FCS_STRIP_EN defined: Rx_FrameSize = count-2 (the two trailing FCS bytes are not readable).
REQ-037 Macro HDLC_RX_FCS_STRIP_EN undefined: Rx_FrameSize = count.

Verification
REQ-038 Flag, bytes 0x11 0x22 0x33 0x44 0x55, flag -> Rx_WrBuff pulses 5 times; Rx_Ready=1; Rx_FrameSize=3 (with macro) or 5 (without); reads return 0x11,0x22,0x33 (with macro) or 0x11..0x55 (without); IDLE after the last read.
REQ-039 Flag, 2 bytes, flag -> Rx_FrameError=1, Rx_Ready=0, Rx_ValidFrame stays 1.
REQ-040 Flag, 3 bytes, Rx_AbortDetect -> Rx_AbortSignal=1 next cycle, Rx_ValidFrame=0; the next flag clears Rx_AbortSignal.
REQ-041 Flag, BUF_DEPTH+1 bytes, flag -> Rx_Overflow=1; exactly BUF_DEPTH Rx_WrBuff pulses; Rx_Ready=1.
REQ-042 Rx_AbortDetect and Rx_FlagDetect in the same cycle mid-frame -> abort taken, state IDLE; in READY, Rx_Drop -> IDLE with no reads.
REQ-043 Rst=0 pulsed mid-FRAME -> all outputs 0 immediately (asynchronously); no Rx_WrBuff pulse until a new flag is received.
